// File: rtl/cordiv_pkg.sv
// Shared width helpers and the est lane-slice index for the correlated divider array.
package cordiv_pkg;

    function automatic int selWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cntWidth(input int win);
        return $clog2(win + 1);
    endfunction

    // The window counter only needs to reach WIN-1, but a zero-width vector is illegal.
    function automatic int wcWidth(input int win);
        return (win > 1) ? $clog2(win) : 1;
    endfunction

    function automatic int estLsb(input int lane, input int cntw);
        return lane * cntw;
    endfunction

endpackage

// File: rtl/cordiv_lane.sv
// One CORDIV lane: quotient history shift register, clamped replay mux and the
// running ones-count of the quotient for the current window.
module cordiv_lane
    import cordiv_pkg::*;
#(
    parameter int                 SRDEPTH = 2,
    parameter logic [SRDEPTH-1:0] SR_INIT = '0,
    parameter int                 SELW    = selWidth(SRDEPTH),
    parameter int                 CNTW    = 9
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic            winEnd,
    input  logic [SELW-1:0] sel,
    input  logic            dividend,
    input  logic            divisor,
    output logic            quotient,
    output logic [CNTW-1:0] count
);

    localparam logic [SELW-1:0] MAX_SEL = SELW'(SRDEPTH - 1);

    logic [SRDEPTH-1:0] r_sr;
    logic [CNTW-1:0]    r_acc;
    logic [SELW-1:0]    w_effSel;

    // Selects beyond the last entry (non-power-of-2 depth) replay the oldest entry.
    assign w_effSel = (sel > MAX_SEL) ? MAX_SEL : sel;
    assign quotient = divisor ? dividend : r_sr[w_effSel];
    assign count    = r_acc + CNTW'(quotient);

    // Newest bit enters at the top; only cycles with a real divisor bit are recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= SR_INIT;
        end else if (clr) begin
            r_sr <= SR_INIT;
        end else if (en && divisor) begin
            r_sr <= {quotient, r_sr[SRDEPTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= winEnd ? '0 : count;
        end
    end

endmodule

// File: rtl/cordiv_array.sv
// NCH-lane correlated stochastic divider with a shared window counter that
// latches a per-lane binary ones-count estimate at the end of every window.
module cordiv_array
    import cordiv_pkg::*;
#(
    parameter int                 NCH     = 4,
    parameter int                 SRDEPTH = 2,
    parameter logic [SRDEPTH-1:0] SR_INIT = '0,
    parameter int                 WIN     = 256,
    parameter int                 SELW    = selWidth(SRDEPTH),
    parameter int                 CNTW    = cntWidth(WIN)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic [SELW-1:0]     sel,
    input  logic [NCH-1:0]      dividend,
    input  logic [NCH-1:0]      divisor,
    output logic [NCH-1:0]      quotient,
    output logic [NCH*CNTW-1:0] est,
    output logic                est_valid
);

    localparam int             WCW     = wcWidth(WIN);
    localparam logic [WCW-1:0] WC_LAST = WCW'(WIN - 1);

    logic [WCW-1:0]  r_wc;
    logic            r_estValid;
    logic [CNTW-1:0] r_est   [NCH];
    logic [CNTW-1:0] w_count [NCH];
    logic            w_winEnd;

    assign w_winEnd  = en && (r_wc == WC_LAST);
    assign est_valid = r_estValid;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        cordiv_lane #(
            .SRDEPTH (SRDEPTH),
            .SR_INIT (SR_INIT),
            .SELW    (SELW),
            .CNTW    (CNTW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clr      (clr),
            .winEnd   (w_winEnd),
            .sel      (sel),
            .dividend (dividend[i]),
            .divisor  (divisor[i]),
            .quotient (quotient[i]),
            .count    (w_count[i])
        );

        assign est[estLsb(i, CNTW) +: CNTW] = r_est[i];
    end

    // Clear restarts the window but deliberately keeps the last published estimate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wc       <= '0;
            r_estValid <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_est[i] <= '0;
            end
        end else if (clr) begin
            r_wc       <= '0;
            r_estValid <= 1'b0;
        end else begin
            r_estValid <= w_winEnd;
            if (en) begin
                r_wc <= w_winEnd ? '0 : r_wc + WCW'(1);
            end
            if (w_winEnd) begin
                for (int i = 0; i < NCH; i++) begin
                    r_est[i] <= w_count[i];
                end
            end
        end
    end

endmodule

// File: doc/cordiv_array.md
Name: cordiv_array

Overview:
- Multi-channel, parametrised stochastic correlated divider (CORDIV) for the SC unit library.
- Each lane outputs quotient = dividend/divisor for correlated unipolar bitstreams. It passes the dividend bit when the divisor bit is 1. Otherwise it replays a past quotient bit from a per-lane shift register, indexed by an externally supplied random select.
- Generalises the single-lane divider: configurable depth, N lanes, enable/clear control, and an on-block windowed ones-counter that emits a binary quotient estimate per lane.

Parameters:
- NCH, 4, number of independent divider lanes (>=1)
- SRDEPTH, 2, quotient history depth per lane (>=2)
- SR_INIT, 0, SRDEPTH-bit reset/clear pattern loaded into every lane's shift register
- WIN, 256, evaluation window length in enabled cycles (>=1)
- SELW, $clog2(SRDEPTH), derived: select width
- CNTW, $clog2(WIN+1), derived: estimate width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  advance enable; low freezes all state
- clr  in  1  synchronous clear of shift registers, counters and window position
- sel  in  SELW  history index, shared by all lanes (from RNG)
- dividend  in  NCH  dividend bitstream, one bit per lane
- divisor  in  NCH  divisor bitstream, one bit per lane
- quotient  out  NCH  quotient bitstream, combinational
- est  out  NCH*CNTW  latched ones-count of quotient over last window; lane i at [i*CNTW +: CNTW]
- est_valid  out  1  one-cycle pulse when est updates

Behaviour:
- Reset (rst=1, async): every lane SR = SR_INIT; ones-counters = 0; window counter = 0; est = 0; est_valid = 0.
- Select: eff_sel = min(sel, SRDEPTH-1). Out-of-range sel (non-power-of-2 depth) clamps to the oldest entry.
- Quotient: quotient[i] = divisor[i] ? dividend[i] : SR_i[eff_sel]. Combinational, zero latency, valid independent of en.
- SR ordering: index SRDEPTH-1 holds the newest bit; index 0 holds the oldest.
- SR update on rising edge with en=1, clr=0, divisor[i]=1: SR_i <= {quotient[i], SR_i[SRDEPTH-1:1]}.
- SR hold: divisor[i]=0 or en=0.
- Window counter wc counts 0..WIN-1 and advances only when en=1.
- Per-lane accumulator acc_i (CNTW bits) adds quotient[i] each enabled cycle.
- Window end (en=1 and wc==WIN-1):
  - est lane i <= acc_i + quotient[i], so the final bit is included.
  - acc_i <= 0; wc <= 0.
  - est_valid = 1 for the following cycle only.
- Overflow: impossible; max count WIN fits CNTW.
- clr=1 (sync, higher priority than en):
  - SR_i <= SR_INIT; acc_i <= 0; wc <= 0; est_valid <= 0.
  - est holds its last value.
- en=0 mid-window: SR, acc, wc, est hold; est_valid <= 0; no pulse is generated.
- Reset asserted mid-window: immediate return to reset values. The partial window is discarded.
- Lanes are fully independent except for the shared sel, en, clr and window timing.

Decomposition:
- Package cordiv_pkg: width-derivation helper functions (SELW, CNTW); lane-slice index function for est.
- Sub-module cordiv_lane: one lane, containing the SR, clamped mux, quotient logic and acc_i. Instantiate NCH times by generate.
- Top level holds wc, est_valid and est registers.

Test Plan:
- Reset/init, SRDEPTH=2, SR_INIT=2'b10, divisor=0: sel=1 -> quotient=1; sel=0 -> quotient=0, all lanes.
- History order, SRDEPTH=4, SR_INIT=0, divisor=1, dividend=1,0,0,1 over 4 enabled cycles; then divisor=0:
  - sel=0 -> 1; sel=1 -> 0; sel=2 -> 0; sel=3 -> 1.
  - Output holds across 10 cycles of divisor=0.
- Enable/clamp, SRDEPTH=3, SR=3'b100, divisor=0:
  - sel=3 -> quotient=SR[2]=1.
  - en=0 with divisor=1, dividend=0 for 5 cycles -> SR unchanged, wc unchanged, no est_valid.
- Window, WIN=8, dividend=divisor=1 on all lanes:
  - est_valid pulses once after the 8th enabled cycle, est=8 per lane.
  - Next window with dividend=0 -> est=0.
- Division accuracy, WIN=256, SRDEPTH=2, correlated streams from a shared 8-bit LFSR, dividend p=64/256, divisor p=128/256:
  - Every lane est within 128+/-16.
  - est_valid exactly every 256 enabled cycles.
- clr/reset mid-window, WIN=8: clr at enabled cycle 5 -> no pulse at cycle 8, next pulse 8 enabled cycles after clr, prior est retained. Repeat with rst at cycle 5 -> est=0, est_valid=0 immediately.
